// File: rtl/game_state_ctrl_if.sv
// game_state_ctrl_if: groups the raw player inputs and the game-state outputs of
// game_state_ctrl into one bundle.
//   sw_raw        raw up/down switch (asynchronous)
//   btn_start_raw raw start/restart button, high = pressed (asynchronous)
//   collide       obstacle-overlap level from the playfield (asynchronous)
//   gamemode      00 idle, 01 playing, 10 game over
//   sw            debounced switch level
//   crash         00 no crash, 11 crash
//   sw_toggle     one-cycle pulse on each accepted sw change
// master: the side that drives the raw inputs; slave: game_state_ctrl itself.
interface game_state_ctrl_if;
    logic       sw_raw;
    logic       btn_start_raw;
    logic       collide;
    logic [1:0] gamemode;
    logic       sw;
    logic [1:0] crash;
    logic       sw_toggle;

    modport master (
        output sw_raw, btn_start_raw, collide,
        input  gamemode, sw, crash, sw_toggle
    );

    modport slave (
        input  sw_raw, btn_start_raw, collide,
        output gamemode, sw, crash, sw_toggle
    );
endinterface

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: synchronizes and debounces the player inputs and runs the
// IDLE -> PLAY -> CRASH -> OVER game-state machine.
// Ports:
//   clk  system clock (100 MHz)
//   rst  asynchronous active-high reset
//   bus  game_state_ctrl_if.slave: sw_raw, btn_start_raw, collide in;
//        gamemode, sw, crash, sw_toggle out (all outputs registered)
module game_state_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned CRASH_HOLD_CYCLES = 110_000_000
) (
    input  logic               clk,
    input  logic               rst,
    game_state_ctrl_if.slave   bus
);

    localparam logic [19:0] DebLast  = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [26:0] HoldLast = 27'(CRASH_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPlay, StCrash, StOver} state_e;

    // Two-flop synchronizers
    logic sw_meta_q, sw_sync_q;
    logic start_meta_q, start_sync_q;
    logic collide_meta_q, collide_sync_q;

    // Debouncers
    logic [19:0] sw_cnt_q, sw_cnt_d;
    logic        sw_lvl_q, sw_lvl_d;
    logic [19:0] start_cnt_q, start_cnt_d;
    logic        start_lvl_q, start_lvl_d;
    logic        start_prev_q;
    logic        start_pulse;

    // FSM and hold counter
    state_e      state_q, state_d;
    logic [26:0] hold_q, hold_d;

    // Registered outputs
    logic [1:0] gamemode_q, gamemode_d;
    logic [1:0] crash_q, crash_d;
    logic       sw_q;
    logic       sw_toggle_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q      <= 1'b0;
            sw_sync_q      <= 1'b0;
            start_meta_q   <= 1'b0;
            start_sync_q   <= 1'b0;
            collide_meta_q <= 1'b0;
            collide_sync_q <= 1'b0;
        end else begin
            sw_meta_q      <= bus.sw_raw;
            sw_sync_q      <= sw_meta_q;
            start_meta_q   <= bus.btn_start_raw;
            start_sync_q   <= start_meta_q;
            collide_meta_q <= bus.collide;
            collide_sync_q <= collide_meta_q;
        end
    end

    // A level is accepted after DEBOUNCE_CYCLES consecutive disagreeing samples;
    // any agreeing sample restarts the count, so the counter never wraps.
    always_comb begin
        sw_cnt_d    = '0;
        sw_lvl_d    = sw_lvl_q;
        start_cnt_d = '0;
        start_lvl_d = start_lvl_q;
        if (sw_sync_q != sw_lvl_q) begin
            if (sw_cnt_q == DebLast) begin
                sw_lvl_d = ~sw_lvl_q;
            end else begin
                sw_cnt_d = sw_cnt_q + 20'd1;
            end
        end
        if (start_sync_q != start_lvl_q) begin
            if (start_cnt_q == DebLast) begin
                start_lvl_d = ~start_lvl_q;
            end else begin
                start_cnt_d = start_cnt_q + 20'd1;
            end
        end
    end

    // Rising edge of the accepted start level; a held button yields one pulse.
    assign start_pulse = start_lvl_q & ~start_prev_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                // collide is deliberately not looked at here
                if (start_pulse) state_d = StPlay;
            end
            StPlay: begin
                if (collide_sync_q) begin
                    state_d = StCrash;
                    hold_d  = '0;
                end
            end
            StCrash: begin
                if (hold_q == HoldLast) begin
                    state_d = StOver;
                end else begin
                    hold_d = hold_q + 27'd1;
                end
            end
            StOver: begin
                if (start_pulse) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output codes decoded from the current state and registered together, so
    // gamemode and crash always move in the same cycle.
    always_comb begin
        gamemode_d = 2'b00;
        crash_d    = 2'b00;
        unique case (state_q)
            StIdle: begin
                gamemode_d = 2'b00;
                crash_d    = 2'b00;
            end
            StPlay: begin
                gamemode_d = 2'b01;
                crash_d    = 2'b00;
            end
            StCrash: begin
                gamemode_d = 2'b01;
                crash_d    = 2'b11;
            end
            StOver: begin
                gamemode_d = 2'b10;
                crash_d    = 2'b11;
            end
            default: begin
                gamemode_d = 2'b00;
                crash_d    = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_cnt_q     <= '0;
            sw_lvl_q     <= 1'b0;
            start_cnt_q  <= '0;
            start_lvl_q  <= 1'b0;
            start_prev_q <= 1'b0;
            state_q      <= StIdle;
            hold_q       <= '0;
            gamemode_q   <= 2'b00;
            crash_q      <= 2'b00;
            sw_q         <= 1'b0;
            sw_toggle_q  <= 1'b0;
        end else begin
            sw_cnt_q     <= sw_cnt_d;
            sw_lvl_q     <= sw_lvl_d;
            start_cnt_q  <= start_cnt_d;
            start_lvl_q  <= start_lvl_d;
            start_prev_q <= start_lvl_q;
            state_q      <= state_d;
            hold_q       <= hold_d;
            gamemode_q   <= gamemode_d;
            crash_q      <= crash_d;
            sw_q         <= sw_lvl_q;
            sw_toggle_q  <= sw_lvl_q ^ sw_q;
        end
    end

    assign bus.gamemode  = gamemode_q;
    assign bus.crash     = crash_q;
    assign bus.sw        = sw_q;
    assign bus.sw_toggle = sw_toggle_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed scenarios for game_state_ctrl with a cycle-level
// behavioural model compared against the outputs on every falling edge, plus
// literal expectations at key points of each scenario.
module tb_game_state_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 20;

    logic clk;
    logic rst;

    game_state_ctrl_if bus ();

    game_state_ctrl #(
        .DEBOUNCE_CYCLES  (DEB),
        .CRASH_HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int tog_count;
    int pulse_count;
    int gm_changes;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each raw input is seen by the logic two edges after it is sampled; a
    // level is accepted once the last DEB seen samples all disagree with it.
    bit [1:0]     m_sw_pipe, m_st_pipe, m_co_pipe;
    bit [DEB-1:0] m_sw_win, m_st_win;
    int           m_sw_fill, m_st_fill;
    bit           m_sw_acc, m_st_acc, m_st_prev;
    int           m_phase;      // 0 idle, 1 play, 2 crash, 3 over
    int           m_cyc;
    int           m_crash_at;
    bit [1:0]     exp_gm, exp_cr;
    bit           exp_sw, exp_tog;

    task automatic m_reset();
        m_sw_pipe = '0; m_st_pipe = '0; m_co_pipe = '0;
        m_sw_win  = '0; m_st_win  = '0;
        m_sw_fill = 0;  m_st_fill = 0;
        m_sw_acc  = 0;  m_st_acc  = 0; m_st_prev = 0;
        m_phase   = 0;  m_cyc = 0; m_crash_at = 0;
        exp_gm    = 2'b00; exp_cr = 2'b00; exp_sw = 0; exp_tog = 0;
    endtask

    task automatic m_step();
        bit sw_seen, st_seen, co_seen, sw_new, st_new, pulse;
        m_cyc++;
        sw_seen   = m_sw_pipe[1];
        st_seen   = m_st_pipe[1];
        co_seen   = m_co_pipe[1];
        m_sw_pipe = {m_sw_pipe[0], bus.sw_raw};
        m_st_pipe = {m_st_pipe[0], bus.btn_start_raw};
        m_co_pipe = {m_co_pipe[0], bus.collide};

        m_sw_win = {m_sw_win[DEB-2:0], sw_seen};
        m_st_win = {m_st_win[DEB-2:0], st_seen};
        if (m_sw_fill < DEB) m_sw_fill++;
        if (m_st_fill < DEB) m_st_fill++;
        sw_new = (m_sw_fill == DEB && m_sw_win == {DEB{~m_sw_acc}}) ? ~m_sw_acc : m_sw_acc;
        st_new = (m_st_fill == DEB && m_st_win == {DEB{~m_st_acc}}) ? ~m_st_acc : m_st_acc;

        pulse     = m_st_acc && !m_st_prev;
        m_st_prev = m_st_acc;
        m_st_acc  = st_new;

        exp_tog  = (m_sw_acc != exp_sw);
        exp_sw   = m_sw_acc;
        m_sw_acc = sw_new;

        case (m_phase)
            0:       begin exp_gm = 2'b00; exp_cr = 2'b00; end
            1:       begin exp_gm = 2'b01; exp_cr = 2'b00; end
            2:       begin exp_gm = 2'b01; exp_cr = 2'b11; end
            default: begin exp_gm = 2'b10; exp_cr = 2'b11; end
        endcase

        case (m_phase)
            0: if (pulse) m_phase = 1;
            1: if (co_seen) begin m_phase = 2; m_crash_at = m_cyc; end
            2: if (m_cyc - m_crash_at == HOLD) m_phase = 3;
            default: if (pulse) m_phase = 0;
        endcase
    endtask

    initial begin : model
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        logic [1:0] prev_gm;
        prev_gm = 2'b00;
        forever begin
            @(negedge clk);
            check("model_gamemode", int'(bus.gamemode), int'(exp_gm));
            check("model_crash", int'(bus.crash), int'(exp_cr));
            check("model_sw", int'(bus.sw), int'(exp_sw));
            check("model_sw_toggle", int'(bus.sw_toggle), int'(exp_tog));
            if (bus.sw_toggle) tog_count++;
            if (dut.start_pulse) pulse_count++;
            if (bus.gamemode != prev_gm) gm_changes++;
            prev_gm = bus.gamemode;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called right after a falling edge, once the compare process has sampled it.
    task automatic clear_counts();
        #1;
        tog_count   = 0;
        pulse_count = 0;
        gm_changes  = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        checks = 0; errors = 0;
        tog_count = 0; pulse_count = 0; gm_changes = 0;
        rst = 1'b1;
        bus.sw_raw = 1'b0; bus.btn_start_raw = 1'b0; bus.collide = 1'b0;
        tick(3);
        check("reset_gamemode", int'(bus.gamemode), 0);
        check("reset_crash", int'(bus.crash), 0);
        check("reset_sw", int'(bus.sw), 0);
        check("reset_sw_toggle", int'(bus.sw_toggle), 0);
        rst = 1'b0;
        tick(3);

        // Bounce: 2-cycle pulses never reach the debounce threshold.
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            bus.sw_raw = (i % 2 == 0);
            tick(2);
            check("bounce_sw_low", int'(bus.sw), 0);
        end
        bus.sw_raw = 1'b1;
        tick(6);
        check("bounce_sw_before_7", int'(bus.sw), 0);
        tick(1);
        check("bounce_sw_at_7", int'(bus.sw), 1);
        check("bounce_toggle_at_7", int'(bus.sw_toggle), 1);
        tick(1);
        check("bounce_toggle_gone", int'(bus.sw_toggle), 0);
        check("bounce_toggle_count", tog_count, 1);

        // Start: held button gives a single pulse and one 00->01 move.
        clear_counts();
        bus.btn_start_raw = 1'b1;
        tick(7);
        check("start_gm_before", int'(bus.gamemode), 0);
        tick(1);
        check("start_gm_play", int'(bus.gamemode), 1);
        check("start_crash_play", int'(bus.crash), 0);
        tick(22);
        bus.btn_start_raw = 1'b0;
        tick(10);
        check("start_pulse_count", pulse_count, 1);
        check("start_gm_changes", gm_changes, 1);

        // Start press while playing is ignored.
        clear_counts();
        bus.btn_start_raw = 1'b1;
        tick(10);
        bus.btn_start_raw = 1'b0;
        tick(12);
        check("play_ignore_gm", int'(bus.gamemode), 1);
        check("play_ignore_changes", gm_changes, 0);

        // Crash: one cycle of collide, start press during CRASH ignored.
        bus.collide = 1'b1;
        tick(1);
        bus.collide = 1'b0;
        tick(2);
        check("crash_not_yet", int'(bus.crash), 0);
        tick(1);
        check("crash_rise_crash", int'(bus.crash), 3);
        check("crash_rise_gm", int'(bus.gamemode), 1);
        tick(1);
        bus.btn_start_raw = 1'b1;
        tick(8);
        bus.btn_start_raw = 1'b0;
        tick(10);
        check("crash_hold_gm", int'(bus.gamemode), 1);
        check("crash_hold_crash", int'(bus.crash), 3);
        tick(1);
        check("over_gm", int'(bus.gamemode), 2);
        check("over_crash", int'(bus.crash), 3);

        // Restart with collide held high.
        bus.collide = 1'b1;
        tick(5);
        check("over_hold_gm", int'(bus.gamemode), 2);
        bus.btn_start_raw = 1'b1;
        tick(10);
        check("restart_idle_gm", int'(bus.gamemode), 0);
        check("restart_idle_crash", int'(bus.crash), 0);
        bus.btn_start_raw = 1'b0;
        tick(10);
        check("idle_collide_ignored", int'(bus.gamemode), 0);
        bus.btn_start_raw = 1'b1;
        tick(8);
        check("replay_gm", int'(bus.gamemode), 1);
        check("replay_crash_low", int'(bus.crash), 0);
        tick(1);
        check("recrash_crash", int'(bus.crash), 3);
        check("recrash_gm", int'(bus.gamemode), 1);
        tick(1);
        bus.btn_start_raw = 1'b0;
        bus.collide = 1'b0;
        tick(4);
        bus.sw_raw = 1'b0;      // sw debounce in flight when reset hits
        tick(4);

        // Asynchronous reset in the middle of CRASH.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_gm", int'(bus.gamemode), 0);
        check("async_rst_crash", int'(bus.crash), 0);
        check("async_rst_sw", int'(bus.sw), 0);
        tick(2);
        rst = 1'b0;
        clear_counts();
        tick(40);
        check("post_rst_toggles", tog_count, 0);
        check("post_rst_gm_changes", gm_changes, 0);
        check("post_rst_pulses", pulse_count, 0);
        check("post_rst_gm", int'(bus.gamemode), 0);
        check("post_rst_crash", int'(bus.crash), 0);

        // sw_raw high after reset gives one toggle at the normal latency.
        bus.sw_raw = 1'b1;
        tick(7);
        check("post_rst_sw", int'(bus.sw), 1);
        tick(5);
        check("post_rst_sw_toggles", tog_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples before a raw input level is accepted (10 ms at 100 MHz).
- CRASH_HOLD_CYCLES, 110_000_000, cycles spent in CRASH before OVER (covers the 1 s crash melody).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, system clock, 100 MHz.
- rst, input, 1, reset, asynchronous, active-high.
- sw_raw, input, 1, raw player up/down switch, asynchronous to clk.
- btn_start_raw, input, 1, raw start/restart push-button, asynchronous, high = pressed.
- collide, input, 1, obstacle-overlap level from the playfield logic, asynchronous.
- gamemode, output, 2, 00 IDLE, 01 playing, 10 game over; 11 never driven.
- sw, output, 1, debounced switch level.
- crash, output, 2, 00 no crash, 11 crash; 01/10 never driven.
- sw_toggle, output, 1, one-cycle pulse on every accepted sw change.

Function
REQ-003 Each raw input (sw_raw, btn_start_raw, collide) SHALL pass through a 2-FF synchronizer before any other use.
REQ-004 sw_raw and btn_start_raw SHALL each have an independent debouncer:
- counter clears whenever the synchronized sample equals the debounced level;
- otherwise the counter increments;
- the debounced level flips in the cycle the counter reaches DEBOUNCE_CYCLES-1, and the counter clears.
REQ-005 Debounce counters SHALL be 20 bits wide; the CRASH hold counter SHALL be 27 bits wide; counters SHALL never wrap.
REQ-006 sw SHALL equal the debounced sw level in every state; sw_toggle SHALL pulse high in the same cycle sw changes.
REQ-007 start_pulse (internal) SHALL be a one-cycle pulse on each 0->1 transition of the debounced start level; holding the button SHALL produce exactly one pulse.
REQ-008 FSM states and outputs SHALL be:
- IDLE: gamemode=00, crash=00.
- PLAY: gamemode=01, crash=00.
- CRASH: gamemode=01, crash=11.
- OVER: gamemode=10, crash=11.
REQ-009 FSM transitions SHALL be:
- IDLE -> PLAY on start_pulse.
- PLAY -> CRASH when synchronized collide=1; the hold counter loads 0.
- CRASH -> OVER when the hold counter reaches CRASH_HOLD_CYCLES-1.
- OVER -> IDLE on start_pulse.
- Otherwise the FSM remains in its current state.
REQ-010 collide SHALL be ignored outside PLAY; a collide that stays high after restart SHALL only act once the FSM is in PLAY again.
REQ-011 start_pulse SHALL be ignored in PLAY and CRASH.
REQ-012 If start_pulse and collide=1 arrive in the same cycle while in IDLE, the FSM SHALL go to PLAY only; collide SHALL be evaluated from the next cycle.
REQ-013 All outputs SHALL be registered; gamemode and crash SHALL change in the cycle after the state register updates (1-cycle output latency), and they SHALL always change together, never as an intermediate code.
REQ-014 crash SHALL rise to 11 while gamemode is still 01, and gamemode SHALL remain 01 for exactly CRASH_HOLD_CYCLES cycles after crash rises, so that the downstream beeper sees the crash edge in play mode.
REQ-015 Latency from a stable sw_raw change to the sw update SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 (output register) cycles.

Reset
REQ-016 On rst=1, regardless of clk, the following SHALL clear: state=IDLE, gamemode=00, crash=00, sw=0, sw_toggle=0, debounced levels=0, all counters=0, synchronizer flops=0.
REQ-017 After rst deasserts, sw_raw held at 1 SHALL produce one sw_toggle after the normal debounce latency.
REQ-018 rst asserted mid-CRASH or mid-debounce SHALL abort the operation with no residual pulse after release.

Verification (DEBOUNCE_CYCLES=4, CRASH_HOLD_CYCLES=20)
REQ-019 The bench SHALL cover the following directed scenarios:
- Bounce: sw_raw toggles every 2 cycles for 20 cycles, then holds 1 -> sw stays 0 during bouncing; exactly one sw_toggle; sw=1 7 cycles after the final edge.
- Start: hold btn_start_raw high for 30 cycles -> gamemode 00->01 once, with a single start_pulse.
- Crash: in PLAY, collide=1 for 1 cycle past the synchronizer -> crash=11 with gamemode=01 for 20 cycles, then gamemode=10 with crash=11.
- Restart: in OVER with collide held at 1, press start -> IDLE (00/00); press start again -> PLAY, then CRASH after sync latency.
- Ignored: start press in PLAY and CRASH -> no state change; collide in IDLE -> gamemode stays 00.
- Reset: assert rst at cycle 10 of CRASH -> gamemode=00 and crash=00 immediately (asynchronously); no output activity after release with inputs at 0.
